// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
// Optional read support is selected with the I2C_TARGET_READ_EN macro.
package i2c_pkg;

    // Default 7-bit address of the camera-side target.
    localparam logic [6:0] CAM_I2C_ADDR = 7'h24;

    // Bit counter width and the two counts the byte FSM cares about.
    localparam int                   BIT_CNT_W = 4;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = 4'd7;
    localparam logic [BIT_CNT_W-1:0] BYTE_DONE = 4'd8;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        ACK_DEV,
        REG_H,
        ACK_H,
        REG_L,
        ACK_L,
        WDATA,
        ACK_W,
        RDATA,
        MACK,
        IGNORE
    } i2c_tgt_state_t;

    // Append one received bit to a byte shifted in MSB first.
    function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b);
        return {cur[6:0], b};
    endfunction

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear; wraps to 0 after MAX.
module counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = (count_q == MAX_C) ? '0 : count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser followed by a one-cycle edge detector.
// Produces SCL edge events and START/STOP conditions in the clk_i domain.
module i2c_line_sync #(
    parameter int SYNC_STAGES_P = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES_P-1:0] scl_sync_q;
    logic [SYNC_STAGES_P-1:0] scl_sync_d;
    logic [SYNC_STAGES_P-1:0] sda_sync_q;
    logic [SYNC_STAGES_P-1:0] sda_sync_d;
    logic                     scl_prev_q;
    logic                     scl_prev_d;
    logic                     sda_prev_q;
    logic                     sda_prev_d;
    logic                     scl_s;

    assign scl_s = scl_sync_q[SYNC_STAGES_P-1];
    assign sda_s = sda_sync_q[SYNC_STAGES_P-1];

    // Shift the raw pads through the chain and remember the previous synced level.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES_P-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES_P-2:0], sda_i};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Chain resets to the idle bus level so reset release creates no false edges.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    // SDA edges only count as START/STOP when SCL was high on both samples.
    always_comb begin
        scl_rise  = scl_s & ~scl_prev_q;
        scl_fall  = ~scl_s & scl_prev_q;
        start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target decoding 7-bit device address + 16-bit register pointer,
// issuing one-cycle write strobes to a local register bank.
// Define I2C_TARGET_READ_EN to add register reads (RDATA/MACK path).
//
// Handshake: reg_we_o is a single-cycle strobe qualifying reg_addr_o and
// reg_wdata_o; reg_re_o is a single-cycle request qualifying reg_addr_o,
// and reg_rdata_i must be valid in the cycle after reg_re_o.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR_P    = CAM_I2C_ADDR,
    parameter int         SYNC_STAGES_P = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe_o,
    output logic [15:0] reg_addr_o,
    output logic [7:0]  reg_wdata_o,
    output logic        reg_we_o,
    output logic        reg_re_o,
    input  logic [7:0]  reg_rdata_i,
    output logic        busy_o
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_line_sync #(
        .SYNC_STAGES_P(SYNC_STAGES_P)
    ) u_line_sync (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda_s    (sda_s)
    );

    logic                 cnt_clr;
    logic                 cnt_inc;
    logic [BIT_CNT_W-1:0] bit_cnt;

    counter #(
        .WIDTH(BIT_CNT_W),
        .MAX  (8)
    ) u_bit_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .count_o(bit_cnt)
    );

    i2c_tgt_state_t state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [15:0]    ptr_q, ptr_d;
    logic           we_q, we_d;
    logic [7:0]     wdata_q, wdata_d;
    logic           sda_oe_q, sda_oe_d;
    logic           busy_q, busy_d;
    logic [7:0]     rx_byte;

`ifdef I2C_TARGET_READ_EN
    logic           re_q, re_d;
    logic [7:0]     tx_q, tx_d;
    logic           rd_pend_q, rd_pend_d;
    logic           mack_ok_q, mack_ok_d;
`else
    logic           unused_rdata;
    assign unused_rdata = ^reg_rdata_i;
`endif

    // Byte as it will look once the bit on the current SCL rise is shifted in.
    assign rx_byte = shift_in(shift_q, sda_s);

    // Address byte acceptance; without read support the R/W=1 form is a mismatch.
    function automatic logic addr_ack(input logic [7:0] b);
`ifdef I2C_TARGET_READ_EN
        return b[7:1] == DEV_ADDR_P;
`else
        return b == {DEV_ADDR_P, 1'b0};
`endif
    endfunction

    // Next-state and output logic; START/STOP override every state.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        sda_oe_d = sda_oe_q;
        busy_d   = busy_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
`ifdef I2C_TARGET_READ_EN
        re_d      = 1'b0;
        tx_d      = tx_q;
        rd_pend_d = re_q;
        mack_ok_d = mack_ok_q;
`endif

        // Pointer post-increments the cycle after each write strobe.
        if (we_q) begin
            ptr_d = ptr_q + 16'd1;
        end

        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            cnt_clr  = 1'b1;
        end else if (start_det) begin
            state_d  = DEV_ADDR;
            sda_oe_d = 1'b0;
            cnt_clr  = 1'b1;
        end else begin
            case (state_q)
                DEV_ADDR, REG_H, REG_L, WDATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_inc = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            if (state_q == WDATA) begin
                                we_d    = 1'b1;
                                wdata_d = rx_byte;
                            end
                            if (state_q == DEV_ADDR && addr_ack(rx_byte)) begin
                                busy_d = 1'b1;
                            end
                        end
                    end else if (scl_fall && bit_cnt == BYTE_DONE) begin
                        cnt_clr  = 1'b1;
                        sda_oe_d = 1'b1;
                        case (state_q)
                            DEV_ADDR: begin
                                if (addr_ack(shift_q)) begin
                                    state_d = ACK_DEV;
                                end else begin
                                    state_d  = IGNORE;
                                    sda_oe_d = 1'b0;
                                end
                            end
                            REG_H: begin
                                ptr_d[15:8] = shift_q;
                                state_d     = ACK_H;
                            end
                            REG_L: begin
                                ptr_d[7:0] = shift_q;
                                state_d    = ACK_L;
                            end
                            default: state_d = ACK_W;
                        endcase
                    end
                end

                // ACK slot ends on the SCL fall after the 9th bit.
                ACK_DEV: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = REG_H;
`ifdef I2C_TARGET_READ_EN
                        // shift_q still holds the address byte; bit 0 is R/W.
                        if (shift_q[0]) begin
                            state_d = RDATA;
                            re_d    = 1'b1;
                        end
`endif
                    end
                end

                ACK_H: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = REG_L;
                    end
                end

                ACK_L, ACK_W: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = WDATA;
                    end
                end

`ifdef I2C_TARGET_READ_EN
                // Load the byte two cycles after the read request, then shift
                // it out MSB first, changing SDA only on SCL falls.
                RDATA: begin
                    if (rd_pend_q) begin
                        tx_d     = reg_rdata_i;
                        sda_oe_d = ~reg_rdata_i[7];
                    end else if (scl_rise) begin
                        cnt_inc = 1'b1;
                    end else if (scl_fall) begin
                        if (bit_cnt == BYTE_DONE) begin
                            cnt_clr   = 1'b1;
                            sda_oe_d  = 1'b0;
                            mack_ok_d = 1'b0;
                            state_d   = MACK;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end

                // Master ACK advances the pointer before the next read request.
                MACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            mack_ok_d = 1'b1;
                            ptr_d     = ptr_q + 16'd1;
                        end
                    end else if (scl_fall) begin
                        if (mack_ok_q) begin
                            re_d    = 1'b1;
                            state_d = RDATA;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
`endif

                IDLE, IGNORE: begin
                    state_d = state_q;
                end

                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            ptr_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            re_q      <= 1'b0;
            tx_q      <= '0;
            rd_pend_q <= 1'b0;
            mack_ok_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            sda_oe_q <= sda_oe_d;
            busy_q   <= busy_d;
`ifdef I2C_TARGET_READ_EN
            re_q      <= re_d;
            tx_q      <= tx_d;
            rd_pend_q <= rd_pend_d;
            mack_ok_q <= mack_ok_d;
`endif
        end
    end

    assign sda_oe_o    = sda_oe_q;
    assign reg_addr_o  = ptr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_we_o    = we_q;
    assign busy_o      = busy_q;
`ifdef I2C_TARGET_READ_EN
    assign reg_re_o    = re_q;
`else
    assign reg_re_o    = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, register-bank stub,
// and a transaction-level model of expected writes, reads and pointer.
module tb_i2c_target_regs;

    localparam int Q = 5;  // quarter SCL period in clk cycles

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        scl_m;
    logic        sda_m;
    logic        sda_i;
    logic        sda_oe_o;
    logic [15:0] reg_addr_o;
    logic [7:0]  reg_wdata_o;
    logic        reg_we_o;
    logic        reg_re_o;
    logic [7:0]  reg_rdata_i = 8'h00;
    logic        busy_o;

    always #5 clk = ~clk;

    // Open-drain wired-AND of master and target on SDA.
    assign sda_i = sda_m & ~sda_oe_o;

    i2c_target_regs dut (
        .clk_i      (clk),
        .rstn_i     (rstn_i),
        .scl_i      (scl_m),
        .sda_i      (sda_i),
        .sda_oe_o   (sda_oe_o),
        .reg_addr_o (reg_addr_o),
        .reg_wdata_o(reg_wdata_o),
        .reg_we_o   (reg_we_o),
        .reg_re_o   (reg_re_o),
        .reg_rdata_i(reg_rdata_i),
        .busy_o     (busy_o)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard state.
    logic [23:0] exp_q[$];
    logic [15:0] exp_r_q[$];
    logic [23:0] got_w_q[$];
    logic [15:0] got_r_q[$];
    int          w_idx = 0;
    int          r_idx = 0;
    logic [15:0] model_ptr = 16'h0000;
    logic [7:0]  wd[8];
    logic        fixed_a5 = 1'b0;

    int oe_cnt = 0;
    int busy_cnt = 0;
    int overlap_cnt = 0;

    function automatic logic [7:0] bank_fn(input logic [15:0] a);
        return a[15:8] ^ {a[6:0], a[7]} ^ 8'h3C;
    endfunction

    // Register bank stub: data valid the cycle after a read request.
    always @(negedge clk) begin
        if (reg_re_o) reg_rdata_i = fixed_a5 ? 8'hA5 : bank_fn(reg_addr_o);
    end

    // Monitor: record strobes and activity counters.
    always @(negedge clk) begin
        if (reg_we_o) got_w_q.push_back({reg_addr_o, reg_wdata_o});
        if (reg_re_o) got_r_q.push_back(reg_addr_o);
        if (reg_we_o && reg_re_o) overlap_cnt++;
        if (sda_oe_o) oe_cnt++;
        if (busy_o) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(2 * Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        b = sda_i;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~mack);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(2 * Q);
    endtask

    // Compare recorded write strobes with the expected queue.
    task automatic drain_writes();
        int n;
        n = got_w_q.size() - w_idx;
        chk("wr_count", 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++)
            chk("wr_addr_data", 32'(got_w_q[w_idx + i]), 32'(exp_q[i]));
        w_idx = got_w_q.size();
        exp_q.delete();
    endtask

    task automatic drain_reads();
        int n;
        n = got_r_q.size() - r_idx;
        chk("rd_req_count", 32'(n), 32'(exp_r_q.size()));
        for (int i = 0; i < n && i < exp_r_q.size(); i++)
            chk("rd_req_addr", 32'(got_r_q[r_idx + i]), 32'(exp_r_q[i]));
        r_idx = got_r_q.size();
        exp_r_q.delete();
    endtask

    // Write transaction: address, pointer high/low, n data bytes from wd[].
    task automatic do_write(input logic [6:0] a7, input logic [15:0] p, input int n);
        logic ack;
        logic hit;
        int   oe0;
        int   busy0;
        hit   = (a7 == 7'h24);
        oe0   = oe_cnt;
        busy0 = busy_cnt;
        i2c_start();
        write_byte({a7, 1'b0}, ack);
        chk("addr_ack", 32'(ack), 32'(hit));
        if (hit) begin
            chk("busy_during", 32'(busy_o), 32'd1);
            write_byte(p[15:8], ack);
            chk("regh_ack", 32'(ack), 32'd1);
            write_byte(p[7:0], ack);
            chk("regl_ack", 32'(ack), 32'd1);
            model_ptr = p;
            for (int i = 0; i < n; i++) begin
                write_byte(wd[i], ack);
                chk("data_ack", 32'(ack), 32'd1);
                exp_q.push_back({model_ptr, wd[i]});
                model_ptr = model_ptr + 16'd1;
            end
        end else begin
            write_byte(p[15:8], ack);
            chk("ignored_ack", 32'(ack), 32'd0);
        end
        i2c_stop();
        chk("oe_after_stop", 32'(sda_oe_o), 32'd0);
        chk("busy_after_stop", 32'(busy_o), 32'd0);
        chk("pointer", 32'(reg_addr_o), 32'(model_ptr));
        if (!hit) begin
            chk("nomatch_oe", 32'(oe_cnt - oe0), 32'd0);
            chk("nomatch_busy", 32'(busy_cnt - busy0), 32'd0);
        end
        drain_writes();
    endtask

`ifdef I2C_TARGET_READ_EN
    // Set pointer by write, repeated START, read n bytes (ACK all but last).
    task automatic do_read(input logic [15:0] p, input int n);
        logic       ack;
        logic [7:0] d;
        logic [7:0] e;
        i2c_start();
        write_byte(8'h48, ack);
        chk("rd_wr_addr_ack", 32'(ack), 32'd1);
        write_byte(p[15:8], ack);
        chk("rd_regh_ack", 32'(ack), 32'd1);
        write_byte(p[7:0], ack);
        chk("rd_regl_ack", 32'(ack), 32'd1);
        model_ptr = p;
        i2c_start();
        write_byte(8'h49, ack);
        chk("rd_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(d, i != n - 1);
            e = fixed_a5 ? 8'hA5 : bank_fn(model_ptr);
            chk("rd_data", 32'(d), 32'(e));
            exp_r_q.push_back(model_ptr);
            if (i != n - 1) model_ptr = model_ptr + 16'd1;
        end
        i2c_stop();
        chk("rd_oe_after_stop", 32'(sda_oe_o), 32'd0);
        chk("rd_pointer", 32'(reg_addr_o), 32'(model_ptr));
        drain_reads();
        drain_writes();
    endtask
`endif

    initial begin
        logic        ack;
        logic [6:0]  a7;
        logic [15:0] p;
        int          n;
        int          oe0;
        int          busy0;

        rstn_i = 1'b0;
        scl_m  = 1'b1;
        sda_m  = 1'b1;
        tick(4);
        chk("rst_sda_oe", 32'(sda_oe_o), 32'd0);
        chk("rst_we", 32'(reg_we_o), 32'd0);
        chk("rst_re", 32'(reg_re_o), 32'd0);
        chk("rst_addr", 32'(reg_addr_o), 32'd0);
        chk("rst_wdata", 32'(reg_wdata_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rstn_i = 1'b1;
        tick(4);

        // Single write 48 01 03 00.
        wd[0] = 8'h00;
        do_write(7'h24, 16'h0103, 1);
        // Burst 48 03 40 02 14.
        wd[0] = 8'h02;
        wd[1] = 8'h14;
        do_write(7'h24, 16'h0340, 2);
        // Wrong address 7'h25.
        wd[0] = 8'hAA;
        do_write(7'h25, 16'h1234, 1);
        // Pointer wrap.
        wd[0] = 8'h5C;
        wd[1] = 8'hC5;
        do_write(7'h24, 16'hFFFF, 2);

        // STOP after 5 bits of a data byte: no strobe, pointer kept.
        i2c_start();
        write_byte(8'h48, ack);
        chk("part_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h01, ack);
        write_byte(8'h03, ack);
        model_ptr = 16'h0103;
        for (int i = 0; i < 5; i++) send_bit(1'(i));
        i2c_stop();
        chk("part_pointer", 32'(reg_addr_o), 32'(model_ptr));
        chk("part_busy", 32'(busy_o), 32'd0);
        drain_writes();

        // Reset asserted while the target drives an ACK.
        i2c_start();
        write_byte(8'h48, ack);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h77 >> i));
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(2);
        chk("ack_driven", 32'(sda_oe_o), 32'd1);
        rstn_i = 1'b0;
        tick(1);
        chk("rst_mid_ack_oe", 32'(sda_oe_o), 32'd0);
        chk("rst_mid_ack_busy", 32'(busy_o), 32'd0);
        rstn_i = 1'b1;
        model_ptr = 16'h0000;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
        i2c_stop();
        chk("rst_mid_ack_ptr", 32'(reg_addr_o), 32'(model_ptr));
        drain_writes();

`ifdef I2C_TARGET_READ_EN
        fixed_a5 = 1'b1;
        do_read(16'h0310, 2);
        fixed_a5 = 1'b0;
        for (int t = 0; t < 4; t++) begin
            p = 16'($urandom);
            if (t == 0) p = 16'hFFFF;
            do_read(p, $urandom_range(1, 3));
        end
`else
        // Read address must be refused when reads are not built in.
        oe0   = oe_cnt;
        busy0 = busy_cnt;
        i2c_start();
        write_byte(8'h49, ack);
        chk("rd_addr_nack", 32'(ack), 32'd0);
        i2c_stop();
        chk("rd_no_req", 32'(got_r_q.size()), 32'd0);
        chk("rd_no_oe", 32'(oe_cnt - oe0), 32'd0);
        chk("rd_no_busy", 32'(busy_cnt - busy0), 32'd0);
`endif

        // Randomized write transactions.
        for (int t = 0; t < 16; t++) begin
            a7 = 7'h24;
            if ($urandom_range(0, 3) == 0) begin
                a7 = 7'($urandom_range(0, 127));
                if (a7 == 7'h24) a7 = 7'h25;
            end
            p = 16'($urandom);
            if ($urandom_range(0, 3) == 0) p = 16'hFFFE;
            n = $urandom_range(1, 4);
            for (int i = 0; i < 8; i++) wd[i] = 8'($urandom);
            do_write(a7, p, n);
        end

        chk("we_re_overlap", 32'(overlap_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
